// File: rtl/dense_ctrl_pkg.sv
// Shared types and defaults for the dense-layer run controller and its benches.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dense_ctrl_pkg;

   // Result format: signed Q8.8 in a 16-bit word.
   localparam int FRAC_BITS = 8;
   localparam int DATA_W    = 16;

   // Default run timing; the accelerator-level benches reuse these.
   localparam int DEF_START_DELAY    = 10;
   localparam int DEF_TIMEOUT_CYCLES = 500000;
   localparam int DEF_CNT_W          = 20;

   // Run controller phases.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DELAY = 3'd1,
      ST_PULSE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_HOLD  = 3'd4
   } run_state_e;

endpackage

// File: rtl/cycle_timer.sv
// Phase counter: clear / load / increment / decrement with a terminal-count compare.
// Latency: count changes on the edge after a strobe; tc_hit compares the registered count.
// Backpressure: none; the owning FSM decides when to strobe.
module cycle_timer #(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             inc,
   input  logic             dec,
   input  logic [CNT_W-1:0] tc_val,
   output logic             tc_hit
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear beats load beats inc beats dec.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (dec) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_hit = (cnt_q == tc_val);

endmodule

// File: rtl/dense_run_controller.sv
// Host-side start/done initiator for the dense accelerator; captures the Q8.8 result.
// Latency: acc_start START_DELAY+1 cycles after an accepted run_req; result 1 cycle after a qualifying done.
// Backpressure: result held in HOLD until res_valid&&res_ready; run_req is ignored (not queued) while busy.
module dense_run_controller #(
   parameter int DATA_W         = dense_ctrl_pkg::DATA_W,
   parameter int START_DELAY    = dense_ctrl_pkg::DEF_START_DELAY,
   parameter int TIMEOUT_CYCLES = dense_ctrl_pkg::DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = dense_ctrl_pkg::DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run_req,
   output logic              run_busy,
   output logic              acc_start,
   input  logic              acc_done,
   input  logic [DATA_W-1:0] acc_result,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_timeout,
   output logic [7:0]        runs_ok,
   output logic [7:0]        runs_to
);

   import dense_ctrl_pkg::*;

   run_state_e        state_q, state_d;
   logic              arm_q, arm_d;
   logic              acc_start_q, acc_start_d;
   logic              run_busy_q, run_busy_d;
   logic              res_valid_q, res_valid_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic              res_timeout_q, res_timeout_d;
   logic [7:0]        runs_ok_q, runs_ok_d;
   logic [7:0]        runs_to_q, runs_to_d;

   logic              tmr_clear;
   logic              tmr_load;
   logic              tmr_inc;
   logic              tmr_dec;
   logic [CNT_W-1:0]  tmr_tc_val;
   logic              tmr_tc;

   logic              done_hit;
   logic              to_hit;
   logic              res_hs;

   // In DELAY the terminal value is 1: the decrement that lands on zero ends the phase,
   // so PULSE is entered START_DELAY edges after the request and acc_start (registered
   // from PULSE) appears one edge later. In WAIT it is the last allowed wait cycle.
   assign tmr_tc_val = (state_q == ST_DELAY) ? CNT_W'(1) : CNT_W'(TIMEOUT_CYCLES - 1);

   // A done level only counts once a low has been seen this run (arm), which rejects a
   // done still held high from the previous run. Done beats the timeout.
   assign done_hit = (state_q == ST_WAIT) && arm_q && acc_done;
   assign to_hit   = (state_q == ST_WAIT) && !done_hit && tmr_tc;
   assign res_hs   = (state_q == ST_HOLD) && res_valid_q && res_ready;

   cycle_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (tmr_clear),
      .load     (tmr_load),
      .load_val (CNT_W'(START_DELAY)),
      .inc      (tmr_inc),
      .dec      (tmr_dec),
      .tc_val   (tmr_tc_val),
      .tc_hit   (tmr_tc)
   );

   // State and registered outputs; reset aborts any run at this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         arm_q         <= 1'b0;
         acc_start_q   <= 1'b0;
         run_busy_q    <= 1'b0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_timeout_q <= 1'b0;
         runs_ok_q     <= '0;
         runs_to_q     <= '0;
      end else begin
         state_q       <= state_d;
         arm_q         <= arm_d;
         acc_start_q   <= acc_start_d;
         run_busy_q    <= run_busy_d;
         res_valid_q   <= res_valid_d;
         res_data_q    <= res_data_d;
         res_timeout_q <= res_timeout_d;
         runs_ok_q     <= runs_ok_d;
         runs_to_q     <= runs_to_d;
      end
   end

   // Next state, timer strobes and arm flag.
   always_comb begin
      state_d   = state_q;
      arm_d     = arm_q;
      tmr_clear = 1'b0;
      tmr_load  = 1'b0;
      tmr_inc   = 1'b0;
      tmr_dec   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run_req) begin
               if (START_DELAY == 0) begin
                  state_d = ST_PULSE;
               end else begin
                  state_d  = ST_DELAY;
                  tmr_load = 1'b1;
               end
            end
         end
         ST_DELAY: begin
            tmr_dec = 1'b1;
            if (tmr_tc) begin
               state_d = ST_PULSE;
            end
         end
         ST_PULSE: begin
            // WAIT starts with a zero count and a disarmed done qualifier.
            tmr_clear = 1'b1;
            arm_d     = 1'b0;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            arm_d = arm_q | ~acc_done;
            if (done_hit || to_hit) begin
               state_d = ST_HOLD;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         ST_HOLD: begin
            if (res_hs) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output register inputs: start pulse, busy, result capture/release and run counters.
   always_comb begin
      acc_start_d   = (state_q == ST_PULSE);
      run_busy_d    = (state_d != ST_IDLE);
      res_valid_d   = res_valid_q;
      res_data_d    = res_data_q;
      res_timeout_d = res_timeout_q;
      runs_ok_d     = runs_ok_q;
      runs_to_d     = runs_to_q;
      if (done_hit) begin
         res_valid_d   = 1'b1;
         res_data_d    = acc_result;
         res_timeout_d = 1'b0;
         runs_ok_d     = runs_ok_q + 8'd1;
      end else if (to_hit) begin
         res_valid_d   = 1'b1;
         res_data_d    = '0;
         res_timeout_d = 1'b1;
         runs_to_d     = runs_to_q + 8'd1;
      end else if (res_hs) begin
         res_valid_d   = 1'b0;
      end
   end

   assign acc_start   = acc_start_q;
   assign run_busy    = run_busy_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_timeout = res_timeout_q;
   assign runs_ok     = runs_ok_q;
   assign runs_to     = runs_to_q;

endmodule

// File: tb/tb_dense_run_controller.sv
// Self-checking bench for dense_run_controller with a waveform-level reference model.
// Latency: n/a.
// Backpressure: exercises held results with res_ready low and run_req held high.
module tb_dense_run_controller;
   import dense_ctrl_pkg::*;

   localparam int DW = 16;
   localparam int SD = 10;
   localparam int TO = 100;
   localparam int CW = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          run_req;
   logic          run_busy;
   logic          acc_start;
   logic          acc_done;
   logic [DW-1:0] acc_result;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;
   logic          res_timeout;
   logic [7:0]    runs_ok;
   logic [7:0]    runs_to;

   int n_checks = 0;
   int n_errors = 0;
   int exp_ok   = 0;
   int exp_to   = 0;

   dense_run_controller #(
      .DATA_W         (DW),
      .START_DELAY    (SD),
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .run_req     (run_req),
      .run_busy    (run_busy),
      .acc_start   (acc_start),
      .acc_done    (acc_done),
      .acc_result  (acc_result),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_timeout (res_timeout),
      .runs_ok     (runs_ok),
      .runs_to     (runs_to)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Done level seen on WAIT sample j (j=0 is the edge after acc_start is observed):
   // hi_n stale-high samples, then lo_n low samples, then high only if done_on.
   function automatic bit done_at(input int j, input int hi_n, input int lo_n, input bit done_on);
      if (j < hi_n) return 1'b1;
      if (j < hi_n + lo_n) return 1'b0;
      return done_on;
   endfunction

   // One complete run: request, start, done/timeout, hold, handshake.
   task automatic run_one(input int hi_n, input int lo_n, input bit done_on,
                          input logic [DW-1:0] result, input int ready_wait, input bit req_hold);
      int            kexp;
      bit            exp_timeout;
      bit            seen_low;
      bit            d;
      bit            got;
      int            n;
      int            j;
      logic [DW-1:0] exp_data;

      // Reference: the result is taken on the first done-high sample that follows a
      // done-low sample of this run; with none in TO samples the run times out.
      kexp        = TO - 1;
      exp_timeout = 1'b1;
      seen_low    = 1'b0;
      for (int i = 0; i < TO; i++) begin
         d = done_at(i, hi_n, lo_n, done_on);
         if (d && seen_low) begin
            kexp        = i;
            exp_timeout = 1'b0;
            break;
         end
         if (!d) seen_low = 1'b1;
      end
      exp_data = exp_timeout ? '0 : result;

      chk("idle_busy", run_busy, 1'b0);
      acc_done   = (hi_n > 0);
      acc_result = result;
      run_req    = 1'b1;
      step();
      run_req = req_hold;
      chk("busy_after_req", run_busy, 1'b1);

      // acc_start must appear SD+1 edges after the accepting edge.
      n   = 0;
      got = 1'b0;
      while (n < SD + 20) begin
         if (acc_start) begin
            got = 1'b1;
            break;
         end
         res_ready = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      res_ready = 1'b0;
      chk("start_seen", got, 1'b1);
      if (!got) return;
      chk("start_latency", n, SD + 1);

      // WAIT phase driven from the done waveform.
      j   = 0;
      got = 1'b0;
      while (j < TO + 10) begin
         acc_done = done_at(j, hi_n, lo_n, done_on);
         step();
         if (j == 0) chk("start_one_cycle", acc_start, 1'b0);
         if (res_valid) begin
            got = 1'b1;
            break;
         end
         j++;
      end
      chk("valid_seen", got, 1'b1);
      if (!got) return;
      chk("valid_latency", j, kexp);

      if (exp_timeout) exp_to++;
      else exp_ok++;
      chk("res_data", res_data, exp_data);
      chk("res_timeout", res_timeout, exp_timeout);
      chk("runs_ok", runs_ok, exp_ok % 256);
      chk("runs_to", runs_to, exp_to % 256);

      // HOLD: result must stay put and no new start may be issued.
      for (int w = 0; w < ready_wait; w++) begin
         acc_done = 1'($urandom_range(0, 1));
         step();
         chk("hold_valid", res_valid, 1'b1);
         chk("hold_data", res_data, exp_data);
         chk("hold_nostart", acc_start, 1'b0);
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("valid_drop", res_valid, 1'b0);
      chk("busy_drop", run_busy, 1'b0);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit any_v;

      reset      = 1'b1;
      run_req    = 1'b0;
      acc_done   = 1'b0;
      acc_result = '0;
      res_ready  = 1'b0;
      step();
      step();
      chk("rst_busy", run_busy, 1'b0);
      chk("rst_start", acc_start, 1'b0);
      chk("rst_valid", res_valid, 1'b0);
      chk("rst_data", res_data, 16'h0);
      chk("rst_timeout", res_timeout, 1'b0);
      chk("rst_ok", runs_ok, 8'h0);
      chk("rst_to", runs_to, 8'h0);
      reset = 1'b0;
      step();

      // Reset mid-WAIT: abort, no result, counters untouched.
      run_req = 1'b1;
      step();
      run_req = 1'b0;
      n = 0;
      while (!acc_start && n < SD + 20) begin
         step();
         n++;
      end
      chk("mid_start_seen", acc_start, 1'b1);
      for (int i = 0; i < 14; i++) step();
      reset = 1'b1;
      step();
      chk("mid_rst_start", acc_start, 1'b0);
      chk("mid_rst_busy", run_busy, 1'b0);
      chk("mid_rst_valid", res_valid, 1'b0);
      chk("mid_rst_data", res_data, 16'h0);
      chk("mid_rst_timeout", res_timeout, 1'b0);
      reset = 1'b0;
      any_v = 1'b0;
      for (int i = 0; i < 30; i++) begin
         acc_done   = (i >= 5);
         acc_result = 16'h1357;
         step();
         if (res_valid) any_v = 1'b1;
      end
      chk("mid_no_valid", any_v, 1'b0);
      chk("mid_busy", run_busy, 1'b0);
      chk("mid_ok", runs_ok, 8'h0);
      chk("mid_to", runs_to, 8'h0);
      acc_done = 1'b0;
      step();

      // Timeout: done never arrives.
      run_one(0, 1, 1'b0, 16'h1234, 2, 1'b0);
      // Normal: done 37 cycles after acc_start, result 1.5.
      run_one(0, 37, 1'b1, 16'(3 << (FRAC_BITS - 1)), 1, 1'b0);
      // Stale done: high through 5 WAIT samples, low 3, then -1.0.
      run_one(5, 3, 1'b1, 16'(-(1 << FRAC_BITS)), 0, 1'b0);
      // Backpressure with run_req held high, then the immediately following run.
      run_one(0, 4, 1'b1, 16'h7FFF, 20, 1'b1);
      run_one(0, 6, 1'b1, 16'h8001, 0, 1'b0);

      // Randomized runs until the success counter has wrapped.
      while (exp_ok < 256) begin
         run_one($urandom_range(0, 3), $urandom_range(1, 30), ($urandom_range(0, 7) != 0),
                 16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         if (n_errors > 20) break;
      end
      run_req = 1'b0;
      chk("wrap_ok", runs_ok, 8'((exp_ok == 256) ? 0 : exp_ok));
      chk("wrap_to", runs_to, 8'(exp_to));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dense_run_controller.md
Name: dense_run_controller

Overview:
- Host-side initiator for the dense-layer accelerator's start/done handshake.
- On a host request, it waits a programmable settle delay and issues a one-cycle `acc_start` pulse.
- It then waits for `acc_done`, or gives up after a cycle timeout, and captures the signed Q8.8 result.
- It presents the result to the host on a valid/ready interface. It sits between the system sequencer and `accelerator_dense`.

Parameters:
- DATA_W, 16, result width; signed Q8.8.
- START_DELAY, 10, cycles between an accepted request and the `acc_start` pulse; 0 is legal.
- TIMEOUT_CYCLES, 500000, maximum cycles waited for `acc_done` after the start pulse.
- CNT_W, 20, counter width; must hold max(START_DELAY, TIMEOUT_CYCLES).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- run_req  in  1  host request; sampled only in IDLE.
- run_busy  out  1  high whenever state != IDLE.
- acc_start  out  1  one-cycle start pulse to the accelerator.
- acc_done  in  1  accelerator done; treated as a level.
- acc_result  in  DATA_W  accelerator final_out, signed Q8.8.
- res_valid  out  1  result available.
- res_ready  in  1  host accepts the result.
- res_data  out  DATA_W  captured result; 0 on timeout.
- res_timeout  out  1  qualifies res_data; 1 means the run timed out.
- runs_ok  out  8  completed-with-done count; wraps 255->0.
- runs_to  out  8  timeout count; wraps 255->0.

Behaviour:
- Reset (synchronous, active-high; the clock is `clk` and the reset is `reset`):
  - state=IDLE.
  - All outputs 0: acc_start, res_valid, res_data, res_timeout, run_busy, runs_ok, runs_to.
  - All counters and the arm flag cleared.
  - Reset asserted mid-run aborts at that edge. acc_start drops at the same edge, and no result or count update is produced.
- All outputs are registered.
- FSM states: IDLE, DELAY, PULSE, WAIT, HOLD.
- IDLE:
  - run_req=1 -> DELAY with cnt=START_DELAY. If START_DELAY=0, go directly to PULSE.
  - run_req is ignored in every other state; no queuing.
- DELAY: cnt decrements each cycle; when cnt reaches 0 -> PULSE. First acc_start occurs START_DELAY+1 cycles after run_req is sampled.
- PULSE:
  - acc_start=1 for exactly this one cycle, then -> WAIT.
  - On entry to WAIT: cnt=0, arm=0.
- WAIT:
  - Arm rule: arm sets on the first cycle acc_done=0 is sampled. A done only qualifies when arm=1 and acc_done=1. This rejects a stale done level held over from the previous run.
  - Qualifying done: res_data<=acc_result (bit-exact, sign preserved), res_timeout<=0, res_valid<=1, runs_ok++ -> HOLD.
  - Otherwise cnt++. When cnt==TIMEOUT_CYCLES-1 with no qualifying done: res_data<=0, res_timeout<=1, res_valid<=1, runs_to++ -> HOLD.
  - A qualifying done and the timeout in the same cycle: done wins.
- HOLD:
  - res_valid, res_data and res_timeout are held stable until res_valid&&res_ready.
  - On that handshake: res_valid<=0 and the FSM goes to IDLE in the same edge. A new run_req is accepted on the following cycle.
  - res_ready while res_valid=0 has no effect.
- run_busy is asserted from the cycle after the accepted request through HOLD.
- No arithmetic on the result; width is preserved. The counters saturate never: they wrap.

Decomposition:
- Shared package `dense_ctrl_pkg`:
  - state enum (IDLE/DELAY/PULSE/WAIT/HOLD);
  - FRAC_BITS=8;
  - DATA_W=16;
  - default TIMEOUT_CYCLES and START_DELAY constants, shared with the accelerator-level benches.
- Sub-module `cycle_timer`: load/clear/increment counter with a terminal-count compare, reused for the DELAY and WAIT phases. Everything else stays flat.

Test Plan:
- Normal run:
  - Stimulus: run_req pulse at cycle 0; model asserts done 37 cycles after acc_start with acc_result=16'sh0180.
  - Required: acc_start high for exactly one cycle at cycle 11 (START_DELAY=10); res_valid with res_data=0x0180 (1.5), res_timeout=0; runs_ok=1.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100; model never asserts done.
  - Required: res_valid 100 cycles after acc_start, with res_timeout=1, res_data=0, runs_to=1, runs_ok=0.
- Stale done:
  - Stimulus: acc_done held high from the previous run through PULSE and 5 WAIT cycles; then low 3 cycles; then high with acc_result=16'shFF00.
  - Required: capture occurs only on the rising done; res_data=0xFF00 (-1.0).
- Backpressure:
  - Stimulus: res_ready low for 20 cycles with run_req held high.
  - Required: res_data stable; no second acc_start. After res_ready, IDLE, then the next start occurs after START_DELAY+1 cycles.
- Reset mid-WAIT:
  - Stimulus: reset asserted 15 cycles after acc_start; done arrives later.
  - Required: all outputs 0 at the reset edge; no res_valid; counts stay 0.
- Wrap:
  - Stimulus: 256 successful runs.
  - Required: runs_ok=0 after the 256th run.
